// File: rtl/ac_pkg.sv
// rtl/ac_pkg.sv - shared FSM type, AXI response codes and prot default for the lite master
package ac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_RESP,
      ST_RSP
   } lite_fsm_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   // States in which the master is waiting on the slave and the timeout runs
   function automatic logic is_wait_state(input lite_fsm_e s);
      return (s == ST_WR_REQ) || (s == ST_WR_RESP) || (s == ST_RD_REQ) || (s == ST_RD_RESP);
   endfunction

endpackage

// File: rtl/crf_lite_master.sv
// rtl/crf_lite_master.sv - single-outstanding AXI4-Lite initiator driven from a cmd/rsp port
module crf_lite_master
   import ac_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst,

   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic                        rsp_write,
   output logic [1:0]                  rsp_resp,
   output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic                        timeout,

   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                  m_axi_awprot,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   input  logic [1:0]                  m_axi_bresp,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                  m_axi_arprot,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp
);

   localparam int SW = AXI_DATA_WIDTH / 8;
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   lite_fsm_e                 state_q, state_d;
   logic                      awvalid_q, awvalid_d;
   logic                      wvalid_q, wvalid_d;
   logic                      bready_q, bready_d;
   logic                      arvalid_q, arvalid_d;
   logic                      rready_q, rready_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic                      rsp_write_q, rsp_write_d;
   logic [1:0]                rsp_resp_q, rsp_resp_d;
   logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [SW-1:0]             wstrb_q, wstrb_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      timeout_q, timeout_d;

   logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;

   assign cmd_ready = (state_q == ST_IDLE);
   assign cmd_fire  = cmd_valid & cmd_ready;
   assign aw_fire   = awvalid_q & m_axi_awready;
   assign w_fire    = wvalid_q & m_axi_wready;
   assign b_fire    = bready_q & m_axi_bvalid;
   assign ar_fire   = arvalid_q & m_axi_arready;
   assign r_fire    = rready_q & m_axi_rvalid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (cmd_fire) state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
         // A channel whose valid already dropped has completed its handshake
         ST_WR_REQ:  if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready))
                        state_d = ST_WR_RESP;
         ST_WR_RESP: if (b_fire) state_d = ST_RSP;
         ST_RD_REQ:  if (ar_fire) state_d = ST_RD_RESP;
         ST_RD_RESP: if (r_fire) state_d = ST_RSP;
         ST_RSP:     if (rsp_ready) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_write_d = rsp_write_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_rdata_d = rsp_rdata_q;
      timeout_d   = timeout_q;
      cnt_d       = '0;

      if (cmd_fire) begin
         addr_d      = cmd_addr;
         wdata_d     = cmd_wdata;
         wstrb_d     = cmd_wstrb;
         rsp_write_d = cmd_write;
         awvalid_d   = cmd_write;
         wvalid_d    = cmd_write;
         arvalid_d   = !cmd_write;
      end
      if (aw_fire) awvalid_d = 1'b0;
      if (w_fire)  wvalid_d  = 1'b0;
      if (ar_fire) arvalid_d = 1'b0;

      if (b_fire) begin
         rsp_resp_d  = m_axi_bresp;
         rsp_rdata_d = '0;
      end
      if (r_fire) begin
         rsp_resp_d  = m_axi_rresp;
         rsp_rdata_d = m_axi_rdata;
      end

      bready_d    = (state_d == ST_WR_RESP);
      rready_d    = (state_d == ST_RD_RESP);
      rsp_valid_d = (state_d == ST_RSP);

      // Counter restarts on every state change and saturates; the FSM keeps waiting
      if ((state_d == state_q) && is_wait_state(state_q)) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
         if (cnt_d == CNT_MAX) timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_resp_q  <= '0;
         rsp_rdata_q <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
      end else begin
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_rdata_q <= rsp_rdata_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign timeout       = timeout_q;

   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = PROT_DEFAULT;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = PROT_DEFAULT;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_crf_lite_master.sv
// tb/tb_crf_lite_master.sv - scoreboard bench for crf_lite_master against a delay-configurable lite slave
module tb_crf_lite_master;
   import ac_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TC = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write;
   logic [1:0]    rsp_resp;
   logic [DW-1:0] rsp_rdata;
   logic          timeout;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   always #5 clk = ~clk;

   crf_lite_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TC)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .timeout(timeout),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
   );

   typedef struct {
      logic          wr;
      logic [1:0]    resp;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   // slave configuration and expectations
   int            aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [DW-1:0] rdata_cfg = '0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_wdata = '0;
   logic [3:0]    exp_wstrb = '0;
   int            aw_hi = 0, w_hi = 0, early_b = 0;

   int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
   bit aw_done = 0, w_done = 0, b_pend = 0, ar_done = 0, r_pend = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Lite slave: ready after N cycles of valid; B/R follow the request after N cycles
   initial begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_done = 0; w_done = 0; b_pend = 0; ar_done = 0; r_pend = 0;
         end else begin
            if (awvalid) begin aw_cnt++; awready = (aw_cnt > aw_delay); end
            else begin aw_cnt = 0; awready = 0; end
            if (wvalid) begin w_cnt++; wready = (w_cnt > w_delay); end
            else begin w_cnt = 0; wready = 0; end
            if (arvalid) begin ar_cnt++; arready = (ar_cnt > ar_delay); end
            else begin ar_cnt = 0; arready = 0; end

            if (b_pend) begin
               bvalid = 0; b_pend = 0; aw_done = 0; w_done = 0; b_cnt = 0;
            end else if (aw_done && w_done) begin
               b_cnt++; bvalid = (b_cnt > b_delay); bresp = bresp_cfg;
            end
            if (bvalid && bready) b_pend = 1;

            if (r_pend) begin
               rvalid = 0; r_pend = 0; ar_done = 0; r_cnt = 0;
            end else if (ar_done) begin
               r_cnt++; rvalid = (r_cnt > r_delay); rdata = rdata_cfg; rresp = rresp_cfg;
            end
            if (rvalid && rready) r_pend = 1;

            if (awvalid && awready) begin
               aw_done = 1;
               check("awaddr", awaddr, exp_addr);
               check("awprot", awprot, PROT_DEFAULT);
            end
            if (wvalid && wready) begin
               w_done = 1;
               check("wdata", wdata, exp_wdata);
               check("wstrb", wstrb, exp_wstrb);
            end
            if (arvalid && arready) begin
               ar_done = 1;
               check("araddr", araddr, exp_addr);
               check("arprot", arprot, PROT_DEFAULT);
            end

            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (bready && (awvalid || wvalid)) early_b++;
         end
      end
   end

   // Response monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL rsp_unexpected: actual resp 0x%0h rdata 0x%0h required none", rsp_resp, rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               check("rsp_write", rsp_write, e.wr);
               check("rsp_resp", rsp_resp, e.resp);
               check("rsp_rdata", rsp_rdata, e.rdata);
            end
         end
      end
   end

   // Returns at the negedge of the cycle after the command handshake
   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [3:0] strb, input logic [1:0] eresp, input logic [DW-1:0] erdata,
                        input bit push);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      exp_addr  = addr;
      exp_wdata = data;
      exp_wstrb = strb;
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept", cmd_ready, 1'b1);
      if (cmd_ready && push) begin
         e.wr = wr; e.resp = eresp; e.rdata = erdata;
         exp_q.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drain", exp_q.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 1;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
      check("rst_timeout", timeout, 1'b0);
      rst = 0;
      @(negedge clk);
      check("idle_cmd_ready", cmd_ready, 1'b1);
      check("idle_regs", {awaddr, wdata, 4'(wstrb)}, 68'h0);

      // zero-wait write, cycle-exact latency
      issue(1, 32'h0, 32'h0000_0001, 4'hF, AXI_RESP_OKAY, 32'h0, 1);
      check("wr_n1_aw_w", {awvalid, wvalid, bready, rsp_valid, cmd_ready}, 5'b11000);
      @(negedge clk);
      check("wr_n2_bready", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
      @(negedge clk);
      check("wr_n3_rsp_valid", {bready, rsp_valid}, 2'b01);
      wait_idle();

      // awready delayed by 5 cycles, wready immediate
      aw_delay = 5;
      aw_hi = 0; w_hi = 0; early_b = 0;
      issue(1, 32'h8, 32'hCAFE_0002, 4'h3, AXI_RESP_OKAY, 32'h0, 1);
      wait_idle();
      check("aw_high_cycles", aw_hi, 6);
      check("w_high_cycles", w_hi, 1);
      check("bready_early", early_b, 0);
      aw_delay = 0;

      // read with 3 wait cycles on R
      r_delay = 3; rdata_cfg = 32'hDEAD_BEEF;
      issue(0, 32'h4, 32'h0, 4'h0, AXI_RESP_OKAY, 32'hDEAD_BEEF, 1);
      wait_idle();
      r_delay = 0;

      // SLVERR write then a DECERR read, both passed through
      bresp_cfg = AXI_RESP_SLVERR;
      issue(1, 32'hC, 32'h1234_5678, 4'hF, AXI_RESP_SLVERR, 32'h0, 1);
      wait_idle();
      bresp_cfg = AXI_RESP_OKAY;
      rresp_cfg = AXI_RESP_DECERR; rdata_cfg = 32'h0000_BEEF;
      issue(0, 32'h10, 32'h0, 4'h0, AXI_RESP_DECERR, 32'h0000_BEEF, 1);
      wait_idle();
      rresp_cfg = AXI_RESP_OKAY;

      // arready withheld: timeout rises at cycle 16 of RD_REQ, late arready completes
      ar_delay = 1000; rdata_cfg = 32'h0BAD_F00D;
      issue(0, 32'h14, 32'h0, 4'h0, AXI_RESP_OKAY, 32'h0BAD_F00D, 1);
      for (int k = 2; k <= 15; k++) @(negedge clk);
      check("timeout_cycle15", timeout, 1'b0);
      @(negedge clk);
      check("timeout_cycle16", {timeout, arvalid}, 2'b11);
      repeat (4) @(negedge clk);
      check("timeout_arvalid_held", {timeout, arvalid}, 2'b11);
      ar_delay = 0;
      wait_idle();
      check("timeout_sticky", timeout, 1'b1);

      // rsp back-pressure, then reset while waiting in RD_RESP
      @(posedge clk); #2 rsp_ready = 0;
      rdata_cfg = 32'hA5A5_0F0F;
      issue(0, 32'h18, 32'h0, 4'h0, AXI_RESP_OKAY, 32'hA5A5_0F0F, 1);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("hold_rsp_valid", rsp_valid, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("hold_rsp_stable", {rsp_valid, rsp_write, 2'(rsp_resp), rsp_rdata, cmd_ready}, {1'b1, 1'b0, 2'b00, 32'hA5A5_0F0F, 1'b0});
      end
      @(posedge clk); #2 rsp_ready = 1;
      wait_idle();

      r_delay = 1000;
      issue(0, 32'h1C, 32'h0, 4'h0, AXI_RESP_OKAY, 32'h0, 0);
      n = 0;
      while (!rready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rd_resp_reached", rready, 1'b1);
      rst = 1;
      #1;
      check("mid_rst_cmd_ready", cmd_ready, 1'b1);
      check("mid_rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, timeout}, 7'b0);
      check("mid_rst_rsp", {rsp_write, 2'(rsp_resp), rsp_rdata}, 35'h0);
      check("mid_rst_regs", {awaddr, wdata, 4'(wstrb)}, 68'h0);
      exp_q.delete();
      r_delay = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 0;

      // normal operation after reset
      issue(1, 32'h20, 32'h5555_AAAA, 4'hC, AXI_RESP_OKAY, 32'h0, 1);
      wait_idle();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
